// File: rtl/trdb_branch_map_replayer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trdb_branch_map_replayer: replays a trace packet's branch map, one outcome per walker handshake.
// Revision: 1.0
// ---------------------------------------------------------------------------
module trdb_branch_map_replayer #(
  parameter int MAP_LEN = 31,
  parameter int CNT_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               pkt_valid_i,
  output logic               pkt_ready_o,
  input  logic [CNT_W-1:0]   pkt_branches_i,
  input  logic [MAP_LEN-1:0] pkt_map_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_taken_o,
  output logic               out_last_o,
  output logic [CNT_W-1:0]   remaining_o,
  output logic               err_o
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic cnt_is_one;
  logic out_hs;
  logic pkt_acc;
  logic pkt_oversize;

  assign cnt_is_one   = (cnt_q == CNT_W'(1));
  assign pkt_oversize = (32'(pkt_branches_i) > 32'(MAP_LEN));

  // Last outcome leaving this cycle frees the map register for the next packet.
  assign pkt_ready_o = (state_q == IDLE) || (cnt_is_one && out_ready_i);
  assign pkt_acc     = pkt_valid_i && pkt_ready_o;
  assign out_hs      = (state_q == REPLAY) && out_ready_i;

  assign out_valid_o = (state_q == REPLAY);
  assign out_taken_o = ~map_q[0];
  assign out_last_o  = (state_q == REPLAY) && cnt_is_one;
  assign remaining_o = cnt_q;
  assign err_o       = err_q;

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (out_hs) begin
      map_d = map_q >> 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_is_one) begin
        state_d = IDLE;
      end
    end

    if (pkt_acc) begin
      if (pkt_branches_i == '0) begin
        state_d = IDLE;
      end else if (pkt_oversize) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        map_d   = pkt_map_i;
        cnt_d   = pkt_branches_i;
        state_d = REPLAY;
      end
    end

    // Flush overrides any load or handshake, and the lost packet raises no error.
    if (flush_i) begin
      state_d = IDLE;
      map_d   = '0;
      cnt_d   = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      map_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trdb_branch_map_replayer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trdb_branch_map_replayer: directed checks of the branch-map replayer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_trdb_branch_map_replayer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        out_ready;

  logic        a_pkt_valid;
  logic        a_pkt_ready;
  logic [4:0]  a_pkt_branches;
  logic [30:0] a_pkt_map;
  logic        a_out_valid;
  logic        a_out_taken;
  logic        a_out_last;
  logic [4:0]  a_remaining;
  logic        a_err;

  logic        b_pkt_valid;
  logic        b_pkt_ready;
  logic [4:0]  b_pkt_branches;
  logic [14:0] b_pkt_map;
  logic        b_out_valid;
  logic        b_out_taken;
  logic        b_out_last;
  logic [4:0]  b_remaining;
  logic        b_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trdb_branch_map_replayer #(.MAP_LEN(31), .CNT_W(5)) u_dut_a (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .pkt_valid_i    (a_pkt_valid),
    .pkt_ready_o    (a_pkt_ready),
    .pkt_branches_i (a_pkt_branches),
    .pkt_map_i      (a_pkt_map),
    .out_valid_o    (a_out_valid),
    .out_ready_i    (out_ready),
    .out_taken_o    (a_out_taken),
    .out_last_o     (a_out_last),
    .remaining_o    (a_remaining),
    .err_o          (a_err)
  );

  trdb_branch_map_replayer #(.MAP_LEN(15), .CNT_W(5)) u_dut_b (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .pkt_valid_i    (b_pkt_valid),
    .pkt_ready_o    (b_pkt_ready),
    .pkt_branches_i (b_pkt_branches),
    .pkt_map_i      (b_pkt_map),
    .out_valid_o    (b_out_valid),
    .out_ready_i    (out_ready),
    .out_taken_o    (b_out_taken),
    .out_last_o     (b_out_last),
    .remaining_o    (b_remaining),
    .err_o          (b_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic v, input logic tk,
                          input logic lst, input logic [4:0] rem);
    #1;
    check_eq({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    if (v) begin
      check_eq({tag, ".taken"}, 32'(a_out_taken), 32'(tk));
      check_eq({tag, ".last"}, 32'(a_out_last), 32'(lst));
    end
    check_eq({tag, ".rem"}, 32'(a_remaining), 32'(rem));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    a_pkt_valid = 1'b0; a_pkt_branches = '0; a_pkt_map = '0;
    b_pkt_valid = 1'b0; b_pkt_branches = '0; b_pkt_map = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    #1;
    check_eq("rst.pkt_ready", 32'(a_pkt_ready), 32'd1);
    check_eq("rst.valid", 32'(a_out_valid), 32'd0);
    check_eq("rst.taken", 32'(a_out_taken), 32'd1);
    check_eq("rst.last", 32'(a_out_last), 32'd0);
    check_eq("rst.rem", 32'(a_remaining), 32'd0);
    check_eq("rst.err", 32'(a_err), 32'd0);

    // Basic replay: 3 branches, map 0b101 -> taken 0,1,0
    tick();
    out_ready = 1'b1;
    a_pkt_valid = 1'b1; a_pkt_branches = 5'd3; a_pkt_map = 31'b101;
    #1 check_eq("basic.accept_ready", 32'(a_pkt_ready), 32'd1);
    tick();
    a_pkt_valid = 1'b0;
    expect_a("basic0", 1'b1, 1'b0, 1'b0, 5'd3);
    tick();
    expect_a("basic1", 1'b1, 1'b1, 1'b0, 5'd2);
    tick();
    expect_a("basic2", 1'b1, 1'b0, 1'b1, 5'd1);
    tick();
    expect_a("basic_done", 1'b0, 1'b0, 1'b0, 5'd0);
    check_eq("basic.ready_after", 32'(a_pkt_ready), 32'd1);

    // Backpressure: 2 branches, map 0b10, walker stalls 4 cycles
    out_ready = 1'b0;
    a_pkt_valid = 1'b1; a_pkt_branches = 5'd2; a_pkt_map = 31'b10;
    tick();
    a_pkt_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_a("bp_hold", 1'b1, 1'b1, 1'b0, 5'd2);
      check_eq("bp.pkt_ready", 32'(a_pkt_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    expect_a("bp0", 1'b1, 1'b1, 1'b0, 5'd2);
    tick();
    expect_a("bp1", 1'b1, 1'b0, 1'b1, 5'd1);
    tick();
    expect_a("bp_done", 1'b0, 1'b0, 1'b0, 5'd0);

    // Back-to-back: A (1 branch, taken) then B (2 branches, not taken twice)
    a_pkt_valid = 1'b1; a_pkt_branches = 5'd1; a_pkt_map = 31'b0;
    tick();
    a_pkt_branches = 5'd2; a_pkt_map = 31'b11;
    expect_a("b2b0", 1'b1, 1'b1, 1'b1, 5'd1);
    check_eq("b2b.pkt_ready", 32'(a_pkt_ready), 32'd1);
    tick();
    a_pkt_valid = 1'b0;
    expect_a("b2b1", 1'b1, 1'b0, 1'b0, 5'd2);
    tick();
    expect_a("b2b2", 1'b1, 1'b0, 1'b1, 5'd1);
    tick();
    expect_a("b2b_done", 1'b0, 1'b0, 1'b0, 5'd0);

    // Zero-branch packet yields nothing
    a_pkt_valid = 1'b1; a_pkt_branches = 5'd0; a_pkt_map = 31'h7fff_ffff;
    tick();
    a_pkt_valid = 1'b0;
    expect_a("zero", 1'b0, 1'b0, 1'b0, 5'd0);
    check_eq("zero.pkt_ready", 32'(a_pkt_ready), 32'd1);
    check_eq("zero.err", 32'(a_err), 32'd0);

    // Full map: 31 outcomes, all taken=0, last only on the final one
    a_pkt_valid = 1'b1; a_pkt_branches = 5'd31; a_pkt_map = 31'h7fff_ffff;
    tick();
    a_pkt_valid = 1'b0;
    for (int i = 0; i < 31; i++) begin
      expect_a("full", 1'b1, 1'b0, (i == 30), 5'(31 - i));
      tick();
    end
    expect_a("full_done", 1'b0, 1'b0, 1'b0, 5'd0);
    check_eq("full.err", 32'(a_err), 32'd0);

    // Oversize on the 15-entry instance: dropped, sticky error survives flush
    b_pkt_valid = 1'b1; b_pkt_branches = 5'd31; b_pkt_map = 15'h7fff;
    tick();
    b_pkt_valid = 1'b0;
    #1;
    check_eq("ovf.err", 32'(b_err), 32'd1);
    check_eq("ovf.valid", 32'(b_out_valid), 32'd0);
    check_eq("ovf.rem", 32'(b_remaining), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 check_eq("ovf.err_after_flush", 32'(b_err), 32'd1);

    // Flush mid-replay: 5 branches, consume 2, flush
    tick();
    a_pkt_valid = 1'b1; a_pkt_branches = 5'd5; a_pkt_map = 31'b00110;
    tick();
    a_pkt_valid = 1'b0;
    expect_a("fl0", 1'b1, 1'b1, 1'b0, 5'd5);
    tick();
    expect_a("fl1", 1'b1, 1'b0, 1'b0, 5'd4);
    tick();
    expect_a("fl2", 1'b1, 1'b0, 1'b0, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expect_a("fl_after", 1'b0, 1'b0, 1'b0, 5'd0);
    a_pkt_valid = 1'b1; a_pkt_branches = 5'd1; a_pkt_map = 31'b1;
    tick();
    a_pkt_valid = 1'b0;
    expect_a("fl_new", 1'b1, 1'b0, 1'b1, 5'd1);
    tick();
    expect_a("fl_new_done", 1'b0, 1'b0, 1'b0, 5'd0);

    // Reset mid-replay on the instance holding err=1
    out_ready = 1'b0;
    b_pkt_valid = 1'b1; b_pkt_branches = 5'd3; b_pkt_map = 15'b110;
    tick();
    b_pkt_valid = 1'b0;
    #1;
    check_eq("rstm.pre_valid", 32'(b_out_valid), 32'd1);
    check_eq("rstm.pre_err", 32'(b_err), 32'd1);
    check_eq("rstm.pre_taken", 32'(b_out_taken), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("rstm.pkt_ready", 32'(b_pkt_ready), 32'd1);
    check_eq("rstm.valid", 32'(b_out_valid), 32'd0);
    check_eq("rstm.taken", 32'(b_out_taken), 32'd1);
    check_eq("rstm.last", 32'(b_out_last), 32'd0);
    check_eq("rstm.rem", 32'(b_remaining), 32'd0);
    check_eq("rstm.err", 32'(b_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
